// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_pkg;

  localparam int unsigned RRF_TAG_W = 5;
  localparam int unsigned DATA_W    = 16;

  // One completed result as broadcast on the CDB (24 bits).
  typedef struct packed {
    logic [RRF_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    data;
    logic                 carry;
    logic                 zero;
    logic                 flag_wr;
  } cdb_payload_t;

  // Round-robin candidate index: k steps above ptr, wrapping modulo n.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned k, int unsigned n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side result inputs and CDB broadcast outputs of the arbiter.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) ();

  localparam int unsigned SrcW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][RRF_TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]                req_carry;
  logic [NUM_REQ-1:0]                req_zero;
  logic [NUM_REQ-1:0]                req_flag_wr;
  logic [NUM_REQ-1:0]                req_ready;

  logic                 cdb_valid;
  logic [RRF_TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  logic                 cdb_carry;
  logic                 cdb_zero;
  logic                 cdb_flag_wr;
  logic [SrcW-1:0]      cdb_src;

  // Execution pipes plus CDB consumers.
  modport master (
    output req_valid, req_tag, req_data, req_carry, req_zero, req_flag_wr,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_carry, cdb_zero, cdb_flag_wr, cdb_src
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_tag, req_data, req_carry, req_zero, req_flag_wr,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_carry, cdb_zero, cdb_flag_wr, cdb_src
  );

endinterface

// File: rtl/cdb_fifo.sv
// Single-requester result FIFO; no bypass, so a pushed entry is visible next cycle.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  cdb_payload_t wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output cdb_payload_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  cdb_payload_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full/empty guards keep the FIFO safe even if the caller does not gate.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next-state pointers and occupancy; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbitration of per-pipe result FIFOs onto a registered common data bus.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus,
  output logic          overflow
);

  localparam int unsigned SrcW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] full, empty, push, pop;
  cdb_payload_t       wdata [NUM_REQ];
  cdb_payload_t       head  [NUM_REQ];

  logic            gnt_found, gnt;
  logic [SrcW-1:0] gnt_idx, cand;

  logic            cdb_valid_q;
  cdb_payload_t    cdb_q;
  logic [SrcW-1:0] cdb_src_q;
  logic [SrcW-1:0] rr_ptr_q;
  logic            overflow_q;

  // Gather per-pipe payloads and gate pushes on room and flush.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      wdata[i].tag     = bus.req_tag[i];
      wdata[i].data    = bus.req_data[i];
      wdata[i].carry   = bus.req_carry[i];
      wdata[i].zero    = bus.req_zero[i];
      wdata[i].flag_wr = bus.req_flag_wr[i];
      push[i]          = bus.req_valid[i] & ~full[i] & ~flush;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    cdb_fifo #(
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[gi]),
      .pop_i   (pop[gi]),
      .flush_i (flush),
      .wdata_i (wdata[gi]),
      .full_o  (full[gi]),
      .empty_o (empty[gi]),
      .head_o  (head[gi])
    );
  end

  assign bus.req_ready = ~full;

  // Search upward from rr_ptr+1 for the first non-empty FIFO; flush cancels the grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SrcW'(rr_next(32'(rr_ptr_q), k, NUM_REQ));
      if (!gnt_found && !empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt = gnt_found & ~flush;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pop[i] = gnt && (gnt_idx == SrcW'(i));
    end
  end

  // CDB output register, round-robin pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= SrcW'(NUM_REQ - 1);
      overflow_q  <= 1'b0;
    end else begin
      cdb_valid_q <= gnt;
      if (gnt) begin
        cdb_q     <= head[gnt_idx];
        cdb_src_q <= gnt_idx;
        rr_ptr_q  <= gnt_idx;
      end
      if (|(bus.req_valid & full)) overflow_q <= 1'b1;
    end
  end

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_tag     = cdb_q.tag;
  assign bus.cdb_data    = cdb_q.data;
  assign bus.cdb_carry   = cdb_q.carry;
  assign bus.cdb_zero    = cdb_q.zero;
  assign bus.cdb_flag_wr = cdb_q.flag_wr;
  assign bus.cdb_src     = cdb_src_q;
  assign overflow        = overflow_q;

endmodule
